imem_dmem_arbiter: RTL and testbench

Shares one single-port memory between the instruction-fetch requester (port I) and the load/store requester (port D) of the core. Accepts one request at a time with a valid/ready handshake, drives it to memory, waits for the memory response, and returns the response to the requester that owns the transaction. A watchdog converts a stalled memory access into an error response.

---
 rtl/imem_dmem_arbiter_if.sv | 48 ++++
 rtl/imem_dmem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle for imem_dmem_arbiter: fetch port, load/store port and memory side.
// The slave modport is the arbiter's view; master is the surrounding core/memory.
interface imem_dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          if_rsp_err;

  logic          d_req_valid;
  logic          d_req_ready;
  logic          d_req_we;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic          d_rsp_err;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  mem_ack, mem_rvalid, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output mem_ack, mem_rvalid, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D) requesters,
// one transaction at a time, with a WAIT watchdog. Define ARB_RR_EN for round-robin.
module imem_dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  imem_dmem_arbiter_if.slave bus
);

  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic       {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  state_e         state_q, state_d;
  owner_e         owner_q, owner_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           we_q, we_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic           if_rsp_valid_q, if_rsp_valid_d;
  logic           if_rsp_err_q, if_rsp_err_d;
  logic [DW-1:0]  if_rsp_data_q, if_rsp_data_d;
  logic           d_rsp_valid_q, d_rsp_valid_d;
  logic           d_rsp_err_q, d_rsp_err_d;
  logic [DW-1:0]  d_rsp_data_q, d_rsp_data_d;

  logic           grant_i, grant_d;
  logic           if_ready, d_ready, accept;
  logic           mem_req, mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           rsp_fire;
  logic [DW-1:0]  rsp_data;

`ifdef ARB_RR_EN
  owner_e rr_last_q, rr_last_d;

  // On a conflict the port that was not served last wins.
  always_comb begin
    grant_d = bus.d_req_valid && (!bus.if_req_valid || rr_last_q == OWN_I);
    grant_i = bus.if_req_valid && !grant_d;
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (accept) rr_last_d = d_ready ? OWN_D : OWN_I;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_last_q <= OWN_D;
    else        rr_last_q <= rr_last_d;
  end
`else
  always_comb begin
    grant_d = bus.d_req_valid;
    grant_i = bus.if_req_valid && !bus.d_req_valid;
  end
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: if (bus.mem_ack) state_d = S_WAIT;
      S_WAIT:  if (bus.mem_rvalid || wd_q == WD_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is withheld while reset is asserted so all outputs read 0 in reset.
  always_comb begin
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if_ready = reset && grant_i;
        d_ready  = reset && grant_d;
      end
      S_ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign accept = if_ready || d_ready;

  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    if (accept) begin
      owner_d = d_ready ? OWN_D : OWN_I;
      addr_d  = d_ready ? bus.d_req_addr : bus.if_req_addr;
      we_d    = d_ready && bus.d_req_we;
      wdata_d = d_ready ? bus.d_req_wdata : '0;
    end
    // Watchdog counts WAIT cycles already spent; zero everywhere else.
    wd_d = (state_q == S_WAIT && state_d == S_WAIT) ? wd_q + WDW'(1) : '0;

    rsp_fire = (state_q == S_WAIT) && (state_d == S_IDLE);
    rsp_data = (bus.mem_rvalid && !we_q) ? bus.mem_rdata : '0;

    if_rsp_valid_d = rsp_fire && owner_q == OWN_I;
    if_rsp_err_d   = if_rsp_valid_d && !bus.mem_rvalid;
    if_rsp_data_d  = if_rsp_valid_d ? rsp_data : '0;
    d_rsp_valid_d  = rsp_fire && owner_q == OWN_D;
    d_rsp_err_d    = d_rsp_valid_d && !bus.mem_rvalid;
    d_rsp_data_d   = d_rsp_valid_d ? rsp_data : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q        <= OWN_I;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      wd_q           <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_err_q    <= 1'b0;
      d_rsp_data_q   <= '0;
    end else begin
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      wd_q           <= wd_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_err_q   <= if_rsp_err_d;
      if_rsp_data_q  <= if_rsp_data_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_err_q    <= d_rsp_err_d;
      d_rsp_data_q   <= d_rsp_data_d;
    end
  end

  assign bus.if_req_ready = if_ready;
  assign bus.d_req_ready  = d_ready;
  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.if_rsp_err   = if_rsp_err_q;
  assign bus.if_rsp_data  = if_rsp_data_q;
  assign bus.d_rsp_valid  = d_rsp_valid_q;
  assign bus.d_rsp_err    = d_rsp_err_q;
  assign bus.d_rsp_data   = d_rsp_data_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of arbitration, latency and watchdog.
module tb_imem_dmem_arbiter;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   last_was_d = 1'b1;  // port served most recently, as the model sees it

  imem_dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  imem_dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = '0;
    bus.d_req_valid  = 1'b0;
    bus.d_req_we     = 1'b0;
    bus.d_req_addr   = '0;
    bus.d_req_wdata  = '0;
    bus.mem_ack      = 1'b0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = '0;
  endtask

  // Requesters keep asking with junk while a transaction is in flight.
  task automatic drive_noise();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = $urandom;
    bus.d_req_valid  = 1'b1;
    bus.d_req_we     = 1'($urandom_range(0, 1));
    bus.d_req_addr   = $urandom;
    bus.d_req_wdata  = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {bus.if_req_ready, bus.d_req_ready, bus.mem_req, bus.mem_we,
                          bus.if_rsp_valid, bus.if_rsp_err, bus.d_rsp_valid, bus.d_rsp_err}, '0);
    check({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, '0);
    check({tag, "_rsp"}, {bus.if_rsp_data, bus.d_rsp_data}, '0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rspflags"}, {bus.if_rsp_valid, bus.if_rsp_err, bus.d_rsp_valid, bus.d_rsp_err}, '0);
    check({tag, "_rspdata"}, {bus.if_rsp_data, bus.d_rsp_data}, '0);
  endtask

  // One transaction: accept, ISSUE for ack_dly+1 cycles, rvalid in WAIT cycle
  // rv_wait (0 = never), or reset asserted in WAIT cycle rst_at (0 = never).
  task automatic run_txn(input bit iv, input bit dv, input bit dwe,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                         input int ack_dly, input int rv_wait, input logic [31:0] rdata,
                         input int rst_at);
    bit          win_d;
    bit          exp_we;
    bit          timed_out;
    bit          done;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          k;

    if (iv && dv) begin
`ifdef ARB_RR_EN
      win_d = !last_was_d;
`else
      win_d = 1'b1;
`endif
    end else begin
      win_d = dv;
    end
    exp_addr = win_d ? da : ia;
    exp_we   = win_d && dwe;

    @(negedge clk);
    bus.if_req_valid = iv;
    bus.if_req_addr  = ia;
    bus.d_req_valid  = dv;
    bus.d_req_we     = dwe;
    bus.d_req_addr   = da;
    bus.d_req_wdata  = wd;
    #1;
    check("accept_ready_i", bus.if_req_ready, !win_d);
    check("accept_ready_d", bus.d_req_ready, win_d);
    last_was_d = win_d;

    for (int c = 0; c <= ack_dly; c++) begin
      @(negedge clk);
      drive_noise();
      #1;
      check("issue_mem_req", bus.mem_req, 1'b1);
      check("issue_mem_addr", bus.mem_addr, exp_addr);
      check("issue_mem_we", bus.mem_we, exp_we);
      if (exp_we) check("issue_mem_wdata", bus.mem_wdata, wd);
      check("issue_ready", {bus.if_req_ready, bus.d_req_ready}, 2'b00);
      check_quiet("issue");
      bus.mem_ack = (c == ack_dly);
    end

    k = 0;
    done = 1'b0;
    timed_out = 1'b0;
    while (!done) begin
      @(negedge clk);
      k++;
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b0;
      drive_noise();
      #1;
      check("wait_mem_req", bus.mem_req, 1'b0);
      check("wait_ready", {bus.if_req_ready, bus.d_req_ready}, 2'b00);
      check_quiet("wait");
      if (k == rst_at) begin
        reset = 1'b0;
        #1;
        check_all_zero("in_reset");
        @(negedge clk);
        check_all_zero("in_reset_hold");
        drive_idle();
        reset = 1'b1;
        last_was_d = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_quiet("after_reset");
          check("after_reset_mem_req", bus.mem_req, 1'b0);
        end
        return;
      end
      bus.mem_rvalid = (k == rv_wait);
      bus.mem_rdata  = rdata;
      if (k == rv_wait) done = 1'b1;
      else if (k == TIMEOUT) begin
        done = 1'b1;
        timed_out = 1'b1;
      end
    end

    exp_data = (timed_out || exp_we) ? 32'h0 : rdata;
    @(negedge clk);
    drive_idle();
    #1;
    check("rsp_valid_i", bus.if_rsp_valid, !win_d);
    check("rsp_valid_d", bus.d_rsp_valid, win_d);
    check("rsp_err_i", bus.if_rsp_err, !win_d && timed_out);
    check("rsp_err_d", bus.d_rsp_err, win_d && timed_out);
    check("rsp_data_i", bus.if_rsp_data, win_d ? 32'h0 : exp_data);
    check("rsp_data_d", bus.d_rsp_data, win_d ? exp_data : 32'h0);
    check("rsp_mem_req", bus.mem_req, 1'b0);
    // Stray memory strobes while IDLE must be ignored.
    bus.mem_ack    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = $urandom;

    @(negedge clk);
    drive_idle();
    #1;
    check_quiet("post_rsp");
    check("post_rsp_mem_req", bus.mem_req, 1'b0);
  endtask

  initial begin
    drive_idle();
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("idle_no_req");

    // Single fetch: ack in first ISSUE cycle, rvalid two cycles after ack.
    run_txn(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0, 0, 2, 32'h00a00193, 0);
    // Data write held for three ISSUE cycles.
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 2, 1, 32'h5555AAAA, 0);
    // Conflicts with zero-wait memory.
    for (int n = 0; n < 4; n++)
      run_txn(1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 0, 1, $urandom, 0);
    // Watchdog expiry, then rvalid on the limit cycle.
    run_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 0, 32'h12345678, 0);
    run_txn(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 1, TIMEOUT, 32'hCAFEF00D, 0);
    // Reset mid-WAIT, then a fresh fetch.
    run_txn(1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 0, 0, 32'h0, 5);
    run_txn(1'b1, 1'b0, 1'b0, 32'h4C, 32'h0, 32'h0, 0, 1, 32'h600D600D, 0);

    for (int n = 0; n < 40; n++) begin
      bit iv;
      bit dv;
      int rv;
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!iv && !dv) iv = 1'b1;
      case ($urandom_range(0, 7))
        0:       rv = 0;
        1:       rv = TIMEOUT;
        default: rv = $urandom_range(1, 5);
      endcase
      run_txn(iv, dv, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), rv, $urandom, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
